// File: rtl/mips_core_pkg.sv
// Shared core types: ALU control encoding and the reservation-station entry record.
package mips_core_pkg;

  localparam int PKG_DATA_WIDTH = 32;
  localparam int PKG_TAG_WIDTH  = 4;

  typedef enum logic [3:0] {
    ALU_AND = 4'd0,
    ALU_OR  = 4'd1,
    ALU_ADD = 4'd2,
    ALU_SUB = 4'd6,
    ALU_SLT = 4'd7,
    ALU_NOR = 4'd12
  } alu_ctl_t;

  typedef struct packed {
    logic                      valid;
    alu_ctl_t                  alu_ctl;
    logic [PKG_TAG_WIDTH-1:0]  tag;
    logic                      op1_rdy;
    logic [PKG_TAG_WIDTH-1:0]  op1_src;
    logic [PKG_DATA_WIDTH-1:0] op1_val;
    logic                      op2_rdy;
    logic [PKG_TAG_WIDTH-1:0]  op2_src;
    logic [PKG_DATA_WIDTH-1:0] op2_val;
  } rs_entry_t;

endpackage

// File: rtl/rs_oldest_select.sv
// Age matrix over reservation-station slots; grants the oldest ready slot (one-hot).
module rs_oldest_select #(
  parameter int ENTRIES = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [ENTRIES-1:0] valid,
  input  logic [ENTRIES-1:0] ready,
  input  logic [ENTRIES-1:0] alloc,
  input  logic [ENTRIES-1:0] free,
  output logic [ENTRIES-1:0] grant
);

  // older_reg[i][j] set means slot j was allocated before slot i
  logic [ENTRIES-1:0] older_reg [ENTRIES];

  for (genvar gi = 0; gi < ENTRIES; gi++) begin : g_grant
    assign grant[gi] = ready[gi] & ~(|(older_reg[gi] & ready));
  end

  // A new slot is younger than all survivors; its column is cleared in every other row
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ENTRIES; i++) older_reg[i] <= '0;
    end else begin
      for (int i = 0; i < ENTRIES; i++) begin
        if (alloc[i]) older_reg[i] <= valid & ~free;
        else          older_reg[i] <= older_reg[i] & ~alloc;
      end
    end
  end

endmodule

// File: rtl/alu_issue_scheduler.sv
// Reservation station for the shared integer ALU: captures operands, wakes on CDB, issues oldest ready.
module alu_issue_scheduler
  import mips_core_pkg::*;
#(
  parameter int ENTRIES    = 4,
  parameter int DATA_WIDTH = PKG_DATA_WIDTH,
  parameter int TAG_WIDTH  = PKG_TAG_WIDTH
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         disp_valid,
  output logic                         disp_ready,
  input  alu_ctl_t                     disp_alu_ctl,
  input  logic [TAG_WIDTH-1:0]         disp_tag,
  input  logic                         disp_op1_rdy,
  input  logic                         disp_op2_rdy,
  input  logic [TAG_WIDTH-1:0]         disp_op1_src,
  input  logic [TAG_WIDTH-1:0]         disp_op2_src,
  input  logic [DATA_WIDTH-1:0]        disp_op1_val,
  input  logic [DATA_WIDTH-1:0]        disp_op2_val,
  input  logic                         cdb_valid,
  input  logic [TAG_WIDTH-1:0]         cdb_tag,
  input  logic [DATA_WIDTH-1:0]        cdb_result,
  input  logic                         flush,
  output logic                         iss_valid,
  output alu_ctl_t                     iss_alu_ctl,
  output logic [DATA_WIDTH-1:0]        iss_op1,
  output logic [DATA_WIDTH-1:0]        iss_op2,
  output logic [TAG_WIDTH-1:0]         iss_tag,
  output logic [$clog2(ENTRIES+1)-1:0] occupancy
);

  localparam int OCC_W = $clog2(ENTRIES+1);
  localparam logic [ENTRIES-1:0] ONE = 1;

  rs_entry_t          entry_reg [ENTRIES];
  rs_entry_t          new_entry;
  logic [ENTRIES-1:0] valid_vec, ready_vec, alloc_vec, grant_vec, issue_vec;
  logic               disp_fire;

  for (genvar gi = 0; gi < ENTRIES; gi++) begin : g_status
    assign valid_vec[gi] = entry_reg[gi].valid;
    assign ready_vec[gi] = entry_reg[gi].valid & entry_reg[gi].op1_rdy & entry_reg[gi].op2_rdy;
  end

  always_comb begin
    alloc_vec = '0;
    for (int i = ENTRIES-1; i >= 0; i--) begin
      if (!valid_vec[i]) alloc_vec = ONE << i;
    end
  end

  assign disp_ready = ~(&valid_vec);
  assign disp_fire  = disp_valid & disp_ready & ~flush;
  assign issue_vec  = flush ? '0 : grant_vec;
  assign iss_valid  = |issue_vec;

  rs_oldest_select #(.ENTRIES(ENTRIES)) u_select (
    .clk   (clk),
    .rst_n (rst_n),
    .valid (valid_vec),
    .ready (ready_vec),
    .alloc (disp_fire ? alloc_vec : '0),
    .free  (issue_vec),
    .grant (grant_vec)
  );

  // A producer broadcasting in the dispatch cycle is folded in directly
  always_comb begin
    new_entry         = '0;
    new_entry.valid   = 1'b1;
    new_entry.alu_ctl = disp_alu_ctl;
    new_entry.tag     = disp_tag;
    new_entry.op1_src = disp_op1_src;
    new_entry.op2_src = disp_op2_src;
    new_entry.op1_rdy = disp_op1_rdy | (cdb_valid && cdb_tag == disp_op1_src);
    new_entry.op2_rdy = disp_op2_rdy | (cdb_valid && cdb_tag == disp_op2_src);
    new_entry.op1_val = disp_op1_rdy ? disp_op1_val : cdb_result;
    new_entry.op2_val = disp_op2_rdy ? disp_op2_val : cdb_result;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ENTRIES; i++) entry_reg[i] <= '0;
    end else begin
      for (int i = 0; i < ENTRIES; i++) begin
        if (flush) begin
          entry_reg[i].valid <= 1'b0;
        end else if (disp_fire && alloc_vec[i]) begin
          entry_reg[i] <= new_entry;
        end else begin
          if (issue_vec[i]) entry_reg[i].valid <= 1'b0;
          if (entry_reg[i].valid && !entry_reg[i].op1_rdy && cdb_valid &&
              cdb_tag == entry_reg[i].op1_src) begin
            entry_reg[i].op1_rdy <= 1'b1;
            entry_reg[i].op1_val <= cdb_result;
          end
          if (entry_reg[i].valid && !entry_reg[i].op2_rdy && cdb_valid &&
              cdb_tag == entry_reg[i].op2_src) begin
            entry_reg[i].op2_rdy <= 1'b1;
            entry_reg[i].op2_val <= cdb_result;
          end
        end
      end
    end
  end

  always_comb begin
    iss_alu_ctl = alu_ctl_t'(4'd0);
    iss_tag     = '0;
    iss_op1     = '0;
    iss_op2     = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      if (issue_vec[i]) begin
        iss_alu_ctl = entry_reg[i].alu_ctl;
        iss_tag     = entry_reg[i].tag;
        iss_op1     = entry_reg[i].op1_val;
        iss_op2     = entry_reg[i].op2_val;
      end
    end
  end

  always_comb begin
    occupancy = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      if (valid_vec[i]) occupancy = occupancy + OCC_W'(1);
    end
  end

endmodule
